// File: rtl/codeseq_bit_reader_pkg.sv
// rtl/codeseq_bit_reader_pkg.sv - shared widths and state encoding for the codeseq bit reader
package codeseq_bit_reader_pkg;

    localparam int CODESEQ_AW = 16;
    localparam int CODESEQ_DW = 32;
    localparam int PEEK_W     = 16;
    localparam int FILL_W     = 7;
    localparam int LEN_W      = 5;
    localparam int COUNT_W    = 20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/codeseq_bit_reader_shift_merge.sv
// rtl/codeseq_bit_reader_shift_merge.sv - drop consumed bits, then append a captured word above the remainder
module codeseq_shift_merge
    import codeseq_bit_reader_pkg::*;
#(
    parameter int BUF_W = 64
) (
    input  logic [BUF_W-1:0]      buffer,
    input  logic [FILL_W-1:0]     fill,
    input  logic [LEN_W-1:0]      len,
    input  logic [CODESEQ_DW-1:0] word,
    input  logic                  capture,
    output logic [BUF_W-1:0]      buffer_next,
    output logic [FILL_W-1:0]     fill_next
);

    logic [BUF_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_shifted;

    // Bits above fill are always zero, so the append is a plain OR.
    always_comb begin
        shifted      = buffer >> len;
        fill_shifted = fill - {{(FILL_W-LEN_W){1'b0}}, len};
        buffer_next  = shifted;
        fill_next    = fill_shifted;
        if (capture) begin
            buffer_next = shifted | ({{(BUF_W-CODESEQ_DW){1'b0}}, word} << fill_shifted);
            fill_next   = fill_shifted + FILL_W'(CODESEQ_DW);
        end
    end

endmodule

// File: rtl/codeseq_bit_reader.sv
// rtl/codeseq_bit_reader.sv - LSB-first bit reader streaming codeseq bytes from a word SRAM
module codeseq_bit_reader
    import codeseq_bit_reader_pkg::*;
#(
    parameter int BUF_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CODESEQ_AW-1:0] start_addr,
    output logic                  sram_wen,
    output logic [CODESEQ_AW-1:0] sram_addr,
    input  logic [CODESEQ_DW-1:0] sram_q,
    output logic [PEEK_W-1:0]     bits_out,
    output logic                  bits_valid,
    input  logic                  consume,
    input  logic [LEN_W-1:0]      consume_len,
    output logic [COUNT_W-1:0]    bit_count,
    output logic                  err
);

    state_t                  state;
    logic [BUF_W-1:0]        buffer;
    logic [FILL_W-1:0]       fill;
    logic                    inflight;
    logic                    discard;
    logic [CODESEQ_AW-1:0]   fetch_addr;

    logic                    fetch_req;
    logic                    capture;
    logic                    len_legal;
    logic                    take;
    logic                    bad_len;
    logic [LEN_W-1:0]        shift_len;
    logic [BUF_W-1:0]        buffer_next;
    logic [FILL_W-1:0]       fill_next;

    // Only fetch when the word in flight plus the new one are guaranteed to fit.
    assign fetch_req  = (state == ST_RUN) &&
                        (({1'b0, fill} + (inflight ? 8'd32 : 8'd0)) <= 8'd32);
    assign capture    = inflight && !discard;
    assign bits_valid = (fill >= FILL_W'(PEEK_W));
    assign len_legal  = (consume_len <= LEN_W'(PEEK_W));
    assign take       = consume && bits_valid && len_legal;
    assign bad_len    = consume && bits_valid && !len_legal;
    assign shift_len  = take ? consume_len : '0;

    assign sram_wen  = 1'b0;
    assign sram_addr = fetch_addr;
    assign bits_out  = buffer[PEEK_W-1:0];

    codeseq_shift_merge #(
        .BUF_W(BUF_W)
    ) u_shift_merge (
        .buffer      (buffer),
        .fill        (fill),
        .len         (shift_len),
        .word        (sram_q),
        .capture     (capture),
        .buffer_next (buffer_next),
        .fill_next   (fill_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            buffer     <= '0;
            fill       <= '0;
            inflight   <= 1'b0;
            discard    <= 1'b0;
            fetch_addr <= '0;
            bit_count  <= '0;
            err        <= 1'b0;
        end else if (start) begin
            // Whatever the SRAM returns next cycle belongs to the old stream.
            state      <= ST_RUN;
            buffer     <= '0;
            fill       <= '0;
            inflight   <= 1'b1;
            discard    <= 1'b1;
            fetch_addr <= start_addr;
            bit_count  <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    buffer   <= buffer_next;
                    fill     <= fill_next;
                    inflight <= fetch_req;
                    discard  <= 1'b0;
                    if (fetch_req) begin
                        fetch_addr <= fetch_addr + CODESEQ_AW'(4);
                    end
                    if (take) begin
                        bit_count <= bit_count + {{(COUNT_W-LEN_W){1'b0}}, consume_len};
                    end
                    if (bad_len) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codeseq_bit_reader.sv
// tb/tb_codeseq_bit_reader.sv - self-checking bench for codeseq_bit_reader against a byte-stream reference
module tb_codeseq_bit_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic        sram_wen;
    logic [15:0] sram_addr;
    logic [31:0] sram_q = '0;
    logic [15:0] bits_out;
    logic        bits_valid;
    logic        consume = 1'b0;
    logic [4:0]  consume_len = '0;
    logic [19:0] bit_count;
    logic        err;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          failures = 0;

    codeseq_bit_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_q      (sram_q),
        .bits_out    (bits_out),
        .bits_valid  (bits_valid),
        .consume     (consume),
        .consume_len (consume_len),
        .bit_count   (bit_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sram_q <= {mem[sram_addr + 16'd3], mem[sram_addr + 16'd2],
                   mem[sram_addr + 16'd1], mem[sram_addr]};
    end

    function automatic logic [15:0] exp_peek(input logic [15:0] base, input int pos);
        logic [15:0] r;
        logic [15:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 16; i++) begin
            a    = base + 16'((pos + i) / 8);
            b    = mem[a];
            r[i] = b[(pos + i) % 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] a);
        start = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (sram_addr !== 16'h0) begin failures++; $display("FAIL reset_sram_addr got=%h exp=0000", sram_addr); end
        checks++; if (bits_out !== 16'h0) begin failures++; $display("FAIL reset_bits_out got=%h exp=0000", bits_out); end
        checks++; if (bits_valid !== 1'b0) begin failures++; $display("FAIL reset_bits_valid got=%b exp=0", bits_valid); end
        checks++; if (sram_wen !== 1'b0) begin failures++; $display("FAIL reset_sram_wen got=%b exp=0", sram_wen); end
        checks++; if (bit_count !== 20'h0 || err !== 1'b0) begin failures++; $display("FAIL reset_count_err got=%h/%b exp=0/0", bit_count, err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency_and_consume();
        do_start(16'h0000);
        checks++; if (sram_addr !== 16'h0000) begin failures++; $display("FAIL lat_first_fetch got=%h exp=0000", sram_addr); end
        checks++; if (bits_valid !== 1'b0 || bits_out !== 16'h0) begin failures++; $display("FAIL lat_e0 got=%b/%h exp=0/0000", bits_valid, bits_out); end
        tick();
        checks++; if (bits_valid !== 1'b0) begin failures++; $display("FAIL lat_e1_valid got=%b exp=0", bits_valid); end
        tick();
        checks++; if (bits_valid !== 1'b1) begin failures++; $display("FAIL lat_e2_valid got=%b exp=1", bits_valid); end
        checks++; if (bits_out !== 16'h578B) begin failures++; $display("FAIL lat_e2_bits got=%h exp=578b", bits_out); end
        consume = 1'b1; consume_len = 5'd4;
        tick();
        consume = 1'b0;
        checks++; if (bits_out !== 16'h5578) begin failures++; $display("FAIL consume4_bits got=%h exp=5578", bits_out); end
        checks++; if (bit_count !== 20'd4) begin failures++; $display("FAIL consume4_count got=%0d exp=4", bit_count); end
        consume = 1'b1; consume_len = 5'd16;
        tick();
        consume = 1'b0;
        checks++; if (bits_out !== 16'h93FF) begin failures++; $display("FAIL consume16_bits got=%h exp=93ff", bits_out); end
        checks++; if (bit_count !== 20'd20) begin failures++; $display("FAIL consume16_count got=%0d exp=20", bit_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [$];
        int pos;
        bit seen;
        pos = 0;
        seen = 0;
        do_start(16'h0000);
        addrs.push_back(sram_addr);
        for (int cyc = 0; cyc < 20 && pos < 80; cyc++) begin
            if (sram_addr !== addrs[$]) addrs.push_back(sram_addr);
            if (seen) begin
                checks++; if (bits_valid !== 1'b1) begin failures++; $display("FAIL b2b_bubble cycle=%0d got=%b exp=1", cyc, bits_valid); end
            end
            if (bits_valid) begin
                seen = 1;
                checks++; if (bits_out !== exp_peek(16'h0, pos)) begin failures++; $display("FAIL b2b_bits pos=%0d got=%h exp=%h", pos, bits_out, exp_peek(16'h0, pos)); end
                consume = 1'b1; consume_len = 5'd16;
                pos += 16;
            end else begin
                consume = 1'b0;
            end
            tick();
        end
        consume = 1'b0;
        checks++; if (pos != 80) begin failures++; $display("FAIL b2b_timeout got=%0d exp=80", pos); end
        checks++;
        if (addrs.size() < 4 || addrs[0] !== 16'd0 || addrs[1] !== 16'd4 || addrs[2] !== 16'd8 || addrs[3] !== 16'd12) begin
            failures++; $display("FAIL b2b_addr_seq got=%p exp=0,4,8,12", addrs);
        end
    endtask

    task automatic test_illegal_len();
        do_start(16'h0000);
        repeat (2) tick();
        consume = 1'b1; consume_len = 5'd20;
        tick();
        consume = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", err); end
        checks++; if (bits_out !== 16'h578B) begin failures++; $display("FAIL illegal_bits got=%h exp=578b", bits_out); end
        checks++; if (bit_count !== 20'd0) begin failures++; $display("FAIL illegal_count got=%0d exp=0", bit_count); end
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_sticky got=%b exp=1", err); end
        do_start(16'h0000);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL illegal_clear got=%b exp=0", err); end
    endtask

    task automatic test_consume_invalid();
        do_start(16'h0000);
        consume = 1'b1; consume_len = 5'd20;
        tick();
        consume_len = 5'd8;
        tick();
        consume = 1'b0;
        checks++; if (err !== 1'b0 || bit_count !== 20'd0) begin failures++; $display("FAIL invalid_ignored got=%b/%0d exp=0/0", err, bit_count); end
        checks++; if (bits_out !== 16'h578B) begin failures++; $display("FAIL invalid_bits got=%h exp=578b", bits_out); end
        consume = 1'b1; consume_len = 5'd0;
        tick();
        consume = 1'b0;
        checks++; if (bits_out !== 16'h578B || bit_count !== 20'd0 || err !== 1'b0) begin failures++; $display("FAIL len0_noop got=%h/%0d/%b exp=578b/0/0", bits_out, bit_count, err); end
    endtask

    task automatic test_restart();
        start = 1'b1; start_addr = 16'h0000;
        tick();
        start_addr = 16'h0004;
        tick();
        start = 1'b0;
        checks++; if (sram_addr !== 16'h0004) begin failures++; $display("FAIL restart_addr got=%h exp=0004", sram_addr); end
        tick();
        checks++; if (bits_valid !== 1'b0 || bits_out !== 16'h0) begin failures++; $display("FAIL restart_dropped got=%b/%h exp=0/0000", bits_valid, bits_out); end
        tick();
        checks++; if (bits_valid !== 1'b1 || bits_out !== 16'hD019) begin failures++; $display("FAIL restart_first got=%b/%h exp=1/d019", bits_valid, bits_out); end
        consume = 1'b1; consume_len = 5'd16;
        tick();
        consume = 1'b0;
        checks++; if (bits_out !== 16'hCB62) begin failures++; $display("FAIL restart_second got=%h exp=cb62", bits_out); end
    endtask

    task automatic test_wrap_and_rst();
        do_start(16'hFFFC);
        checks++; if (sram_addr !== 16'hFFFC) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffc", sram_addr); end
        tick();
        checks++; if (sram_addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr1 got=%h exp=0000", sram_addr); end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (bits_valid !== 1'b1 || bits_out !== exp_peek(16'hFFFC, 16 * k)) begin failures++; $display("FAIL wrap_bits k=%0d got=%b/%h exp=1/%h", k, bits_valid, bits_out, exp_peek(16'hFFFC, 16 * k)); end
            consume = 1'b1; consume_len = 5'd16;
            tick();
        end
        consume = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (sram_addr !== 16'h0 || bits_out !== 16'h0 || bits_valid !== 1'b0 || sram_wen !== 1'b0) begin failures++; $display("FAIL midrun_rst got=%h/%h/%b/%b exp=0/0/0/0", sram_addr, bits_out, bits_valid, sram_wen); end
        checks++; if (bit_count !== 20'h0 || err !== 1'b0) begin failures++; $display("FAIL midrun_rst_count got=%h/%b exp=0/0", bit_count, err); end
        rst = 1'b0;
    endtask

    task automatic test_rst_over_start();
        rst = 1'b1; start = 1'b1; start_addr = 16'h0008;
        tick();
        rst = 1'b0; start = 1'b0;
        repeat (3) tick();
        checks++; if (bits_valid !== 1'b0 || sram_addr !== 16'h0) begin failures++; $display("FAIL rst_over_start got=%b/%h exp=0/0000", bits_valid, sram_addr); end
    endtask

    task automatic test_random(input int runs);
        for (int r = 0; r < runs; r++) begin
            logic [15:0] base;
            int pos;
            int idle_run;
            bit exp_err;
            int sel;
            base = 16'($urandom_range(16, 65000));
            pos = 0; idle_run = 0; exp_err = 0;
            do_start(base);
            for (int cyc = 0; cyc < 300; cyc++) begin
                checks++; if (err !== exp_err) begin failures++; $display("FAIL rand_err run=%0d cyc=%0d got=%b exp=%b", r, cyc, err, exp_err); end
                if (bits_valid) begin
                    idle_run = 0;
                    checks++; if (bits_out !== exp_peek(base, pos)) begin failures++; $display("FAIL rand_bits run=%0d pos=%0d got=%h exp=%h", r, pos, bits_out, exp_peek(base, pos)); end
                    checks++; if (bit_count !== 20'(pos)) begin failures++; $display("FAIL rand_count run=%0d got=%0d exp=%0d", r, bit_count, 20'(pos)); end
                end else begin
                    idle_run++;
                end
                checks++; if (idle_run > 4) begin failures++; $display("FAIL rand_starved run=%0d cyc=%0d got=%0d idle exp<=4", r, cyc, idle_run); end
                sel = $urandom_range(0, 9);
                if (sel < 6) begin
                    consume = 1'b1; consume_len = 5'($urandom_range(0, 16));
                end else if (sel == 6) begin
                    consume = 1'b1; consume_len = 5'($urandom_range(17, 31));
                end else begin
                    consume = 1'b0; consume_len = 5'($urandom_range(0, 31));
                end
                if (bits_valid && consume) begin
                    if (consume_len <= 5'd16) pos += int'(consume_len);
                    else exp_err = 1;
                end
                tick();
            end
            consume = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8B; mem[1] = 8'h57; mem[2] = 8'hF5; mem[3] = 8'h3F; mem[4] = 8'h19;
        mem[5] = 8'hD0; mem[6] = 8'h62; mem[7] = 8'hCB; mem[8] = 8'hBE; mem[9] = 8'h01;
        tick();
        test_reset();
        test_latency_and_consume();
        test_back_to_back();
        test_illegal_len();
        test_consume_invalid();
        test_restart();
        test_wrap_and_rst();
        test_rst_over_start();
        test_random(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
